// File: rtl/flag_branch_unit_if.sv
// EX-stage flag inputs, ID-stage branch inputs and registered fetch-redirect outputs.
// Handshake: ex_valid and id_br_valid qualify their groups for one cycle; there is no backpressure.
`timescale 1ns/1ps
interface flag_branch_unit_if #(parameter int DW = 16);
  logic          ex_valid;
  logic [3:0]    ex_op;
  logic [2:0]    ex_flags;
  logic          id_br_valid;
  logic          id_br_reg;
  logic [2:0]    id_ccc;
  logic [8:0]    id_imm9;
  logic [DW-1:0] id_pc_plus2;
  logic [DW-1:0] id_rs_val;
  logic [2:0]    flags_q;
  logic          br_taken;
  logic [DW-1:0] br_target;
  logic          flush;
  logic          dbg_state;

  modport master (
    output ex_valid, ex_op, ex_flags, id_br_valid, id_br_reg, id_ccc, id_imm9,
           id_pc_plus2, id_rs_val,
    input  flags_q, br_taken, br_target, flush, dbg_state
  );

  modport slave (
    input  ex_valid, ex_op, ex_flags, id_br_valid, id_br_reg, id_ccc, id_imm9,
           id_pc_plus2, id_rs_val,
    output flags_q, br_taken, br_target, flush, dbg_state
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural {Z,V,N} flag register with EX->ID forwarding, and a branch resolver
// that issues a registered redirect and ignores the wrong-path slot after a taken branch.
`timescale 1ns/1ps
module flag_branch_unit #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  flag_branch_unit_if.slave    bus
);

  typedef enum logic {S_RESOLVE = 1'b0, S_SHADOW = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_flags;
  logic          r_br_taken;
  logic [DW-1:0] r_br_target;

  logic          w_wr_z;
  logic          w_wr_vn;
  logic [2:0]    w_fwd;
  logic          w_cond;
  logic          w_take;
  logic [DW-1:0] w_target;
  logic [DW-1:0] w_offset;

  always_comb begin
    w_wr_z  = 1'b0;
    w_wr_vn = 1'b0;
    if (bus.ex_valid) begin
      case (bus.ex_op)
        4'b0000, 4'b0001: begin
          w_wr_z  = 1'b1;
          w_wr_vn = 1'b1;
        end
        4'b0010, 4'b0100, 4'b0101, 4'b0110: w_wr_z = 1'b1;
        default: ;
      endcase
    end
  end

  // The forwarded view is also exactly the next architectural flag value.
  assign w_fwd = {w_wr_z  ? bus.ex_flags[2] : r_flags[2],
                  w_wr_vn ? bus.ex_flags[1] : r_flags[1],
                  w_wr_vn ? bus.ex_flags[0] : r_flags[0]};

  always_comb begin
    w_cond = 1'b0;
    case (bus.id_ccc)
      3'b000: w_cond = ~w_fwd[2];
      3'b001: w_cond = w_fwd[2];
      3'b010: w_cond = ~w_fwd[2] & ~w_fwd[0];
      3'b011: w_cond = w_fwd[0];
      3'b100: w_cond = w_fwd[2] | (~w_fwd[2] & ~w_fwd[0]);
      3'b101: w_cond = w_fwd[0] | w_fwd[2];
      3'b110: w_cond = w_fwd[1];
      default: w_cond = 1'b1;
    endcase
  end

  assign w_offset = {{(DW-10){bus.id_imm9[8]}}, bus.id_imm9, 1'b0};
  assign w_target = bus.id_br_reg ? bus.id_rs_val : (bus.id_pc_plus2 + w_offset);

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      S_RESOLVE: begin
        if (bus.id_br_valid && w_cond) begin
          w_take      = 1'b1;
          w_state_nxt = S_SHADOW;
        end
      end
      S_SHADOW: w_state_nxt = S_RESOLVE;
      default:  w_state_nxt = S_RESOLVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RESOLVE;
      r_flags     <= 3'b000;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_flags    <= w_fwd;
      r_br_taken <= w_take;
      if (w_take) r_br_target <= w_target;
    end
  end

  assign bus.flags_q   = r_flags;
  assign bus.br_taken  = r_br_taken;
  assign bus.flush     = r_br_taken;
  assign bus.br_target = r_br_target;
  assign bus.dbg_state = (r_state == S_SHADOW);

endmodule
